// File: rtl/mmio_gpio_port_pkg.sv
// Shared register map, bus handshake states and address decode helper
// for the memory-mapped GPIO port.
package mmio_gpio_port_pkg;

  localparam int GPIO_ADDR_BITS = 3;

  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_OUT     = 3'd0;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_SET     = 3'd1;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_CLR     = 3'd2;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_TGL     = 3'd3;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_IN      = 3'd4;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_RISE_EN = 3'd5;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_FALL_EN = 3'd6;
  localparam logic [GPIO_ADDR_BITS-1:0] GPIO_REG_PEND    = 3'd7;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  function automatic logic addr_match(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:GPIO_ADDR_BITS] == base[31:GPIO_ADDR_BITS];
  endfunction

endpackage

// File: rtl/mmio_gpio_port_if.sv
// CPU data-bus bundle seen by the GPIO block; the CPU side is the master.
interface mmio_gpio_port_if;
  logic [31:0] mem_address;
  logic        mem_valid;
  logic        mem_nwr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ready;
  logic        selected;

  modport master (
    output mem_address, mem_valid, mem_nwr, mem_data_in,
    input  mem_data_out, mem_ready, selected
  );

  modport slave (
    input  mem_address, mem_valid, mem_nwr, mem_data_in,
    output mem_data_out, mem_ready, selected
  );
endinterface

// File: rtl/mmio_gpio_port_sync_edge.sv
// Pin synchroniser chain plus history flop producing per-bit rise/fall vectors.
// Edges stay masked until the chain has been refilled after reset.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_synced,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam int WARM_MAX  = SYNC_STAGES + 1;
  localparam int WARM_BITS = $clog2(WARM_MAX + 1);

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     r_hist;
  logic [WARM_BITS-1:0] r_warm;
  logic                 w_warm;

  // Zeroed flops would otherwise report a fake edge when pins are already high out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
      r_warm <= '0;
    end else begin
      r_sync[0] <= i_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
      if (!w_warm) r_warm <= r_warm + WARM_BITS'(1);
    end
  end

  assign w_warm   = (r_warm == WARM_BITS'(WARM_MAX));
  assign o_synced = r_sync[SYNC_STAGES-1];
  assign o_rise   = w_warm ? (o_synced & ~r_hist) : '0;
  assign o_fall   = w_warm ? (~o_synced & r_hist) : '0;

endmodule

// File: rtl/mmio_gpio_port.sv
// Memory-mapped GPIO port: set/clear/toggle outputs, synchronised inputs and
// per-bit edge interrupts behind a one-cycle-latency CPU bus handshake.
module mmio_gpio_port
  import mmio_gpio_port_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [31:0]      BASE_ADDRESS = 32'hFFFFFFF0,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] OUT_RESET    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0]      i_gpio_in,
  output logic [WIDTH-1:0]      o_gpio_out,
  output logic                  o_interrupt,
  input  logic                  i_interrupt_clear
);

  bus_state_t r_state;
  bus_state_t w_nextState;

  logic                      w_selected;
  logic                      w_accept;
  logic                      w_write;
  logic [GPIO_ADDR_BITS-1:0] w_offset;
  logic [WIDTH-1:0]          w_wdata;
  logic [WIDTH-1:0]          r_out;
  logic [WIDTH-1:0]          r_riseEn;
  logic [WIDTH-1:0]          r_fallEn;
  logic [WIDTH-1:0]          r_pend;
  logic [WIDTH-1:0]          w_synced;
  logic [WIDTH-1:0]          w_rise;
  logic [WIDTH-1:0]          w_fall;
  logic [WIDTH-1:0]          w_pendSet;
  logic [WIDTH-1:0]          w_pendClr;
  logic [WIDTH-1:0]          w_readVal;
  logic [31:0]               r_dataOut;
  logic                      w_unused;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_syncEdge (
    .clk      (clk),
    .reset    (reset),
    .i_pins   (i_gpio_in),
    .o_synced (w_synced),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_selected = addr_match(bus.mem_address, BASE_ADDRESS);
  assign w_offset   = bus.mem_address[GPIO_ADDR_BITS-1:0];
  assign w_wdata    = bus.mem_data_in[WIDTH-1:0];
  assign w_unused   = ^bus.mem_data_in;
  // A held request is only taken once: acceptance requires the idle state
  assign w_accept   = bus.mem_valid && w_selected && (r_state == BUS_IDLE);
  assign w_write    = w_accept && !bus.mem_nwr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= BUS_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BUS_IDLE: if (w_accept) w_nextState = BUS_ACK;
      BUS_ACK:  if (!(bus.mem_valid && w_selected)) w_nextState = BUS_IDLE;
      default:  w_nextState = BUS_IDLE;
    endcase
  end

  always_comb begin
    w_readVal = '0;
    case (w_offset)
      GPIO_REG_OUT:     w_readVal = r_out;
      GPIO_REG_IN:      w_readVal = w_synced;
      GPIO_REG_RISE_EN: w_readVal = r_riseEn;
      GPIO_REG_FALL_EN: w_readVal = r_fallEn;
      GPIO_REG_PEND:    w_readVal = r_pend;
      default:          w_readVal = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         r_dataOut <= '0;
    else if (w_accept) r_dataOut <= 32'(w_readVal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out    <= OUT_RESET;
      r_riseEn <= '0;
      r_fallEn <= '0;
    end else if (w_write) begin
      case (w_offset)
        GPIO_REG_OUT:     r_out    <= w_wdata;
        GPIO_REG_SET:     r_out    <= r_out | w_wdata;
        GPIO_REG_CLR:     r_out    <= r_out & ~w_wdata;
        GPIO_REG_TGL:     r_out    <= r_out ^ w_wdata;
        GPIO_REG_RISE_EN: r_riseEn <= w_wdata;
        GPIO_REG_FALL_EN: r_fallEn <= w_wdata;
        default:          ;
      endcase
    end
  end

  // Set is OR-ed in after the clear so an edge coinciding with an ack is never lost
  assign w_pendSet = (w_rise & r_riseEn) | (w_fall & r_fallEn);
  assign w_pendClr = {WIDTH{i_interrupt_clear}} |
                     ((w_write && (w_offset == GPIO_REG_PEND)) ? w_wdata : '0);

  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~w_pendClr) | w_pendSet;
  end

  assign bus.mem_ready    = (r_state == BUS_ACK);
  assign bus.mem_data_out = r_dataOut;
  assign bus.selected     = w_selected;
  assign o_gpio_out       = r_out;
  assign o_interrupt      = |r_pend;

endmodule

// File: tb/tb_mmio_gpio_port.sv
// Self-checking bench for mmio_gpio_port: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_mmio_gpio_port;

  localparam int          W       = 8;
  localparam int          S       = 2;
  localparam logic [31:0] BASE    = 32'hFFFFFFF0;
  localparam logic [7:0]  OUT_RST = 8'hA5;

  typedef struct {
    logic        nwr;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [7:0]  expOut;
    logic [31:0] expRead;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pins;
  logic [W-1:0] gpioOut;
  logic         irq;
  logic         intClr;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mOut, mRise, mFall, mPend;
  logic        mReady;
  logic [31:0] mData;
  logic [7:0]  mQ[$];
  int          mWarm;

  vec_t        vecs[10];
  logic [31:0] rd;
  int          r;

  mmio_gpio_port_if bus();

  mmio_gpio_port #(
    .WIDTH        (W),
    .BASE_ADDRESS (BASE),
    .SYNC_STAGES  (S),
    .OUT_RESET    (OUT_RST)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .i_gpio_in         (pins),
    .o_gpio_out        (gpioOut),
    .o_interrupt       (irq),
    .i_interrupt_clear (intClr)
  );

  always #5 clk = ~clk;

  // Reference: pins pass through a plain delay line; the synced value is the
  // sample taken S-1 edges ago and the history one edge older than that.
  task automatic modelStep();
    logic [7:0] syncV, histV, setV, clrV, rv, d;
    logic       sel, acc;
    logic [2:0] off;
    if (reset) begin
      mOut = OUT_RST; mRise = 8'h00; mFall = 8'h00; mPend = 8'h00;
      mReady = 1'b0; mData = 32'h0; mWarm = 0;
      mQ.delete();
      for (int i = 0; i <= S; i++) mQ.push_back(8'h00);
      return;
    end
    sel   = (bus.mem_address[31:3] == BASE[31:3]);
    off   = bus.mem_address[2:0];
    d     = bus.mem_data_in[7:0];
    acc   = bus.mem_valid && sel && !mReady;
    syncV = mQ[1];
    histV = mQ[0];
    setV  = (mWarm >= S + 1) ? ((syncV & ~histV & mRise) | (~syncV & histV & mFall)) : 8'h00;
    clrV  = intClr ? 8'hFF : 8'h00;
    if (acc) begin
      case (off)
        3'd0:    rv = mOut;
        3'd4:    rv = syncV;
        3'd5:    rv = mRise;
        3'd6:    rv = mFall;
        3'd7:    rv = mPend;
        default: rv = 8'h00;
      endcase
      mData = {24'h0, rv};
      if (!bus.mem_nwr) begin
        case (off)
          3'd0:    mOut = d;
          3'd1:    mOut = mOut | d;
          3'd2:    mOut = mOut & ~d;
          3'd3:    mOut = mOut ^ d;
          3'd5:    mRise = d;
          3'd6:    mFall = d;
          3'd7:    clrV = clrV | d;
          default: ;
        endcase
      end
    end
    mPend  = (mPend & ~clrV) | setV;
    mReady = bus.mem_valid && sel;
    mQ.push_back(pins);
    void'(mQ.pop_front());
    if (mWarm < S + 1) mWarm++;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, ".gpioOut"},  32'(gpioOut), 32'(mOut));
    checkVal({name, ".irq"},      32'(irq), 32'(|mPend));
    checkVal({name, ".ready"},    32'(bus.mem_ready), 32'(mReady));
    checkVal({name, ".dataOut"},  bus.mem_data_out, mData);
    checkVal({name, ".selected"}, 32'(bus.selected), 32'(bus.mem_address[31:3] == BASE[31:3]));
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic nwr, input logic [31:0] data);
    bus.mem_valid   = valid;
    bus.mem_address = addr;
    bus.mem_nwr     = nwr;
    bus.mem_data_in = data;
  endtask

  task automatic busWrite(input string name, input logic [2:0] off, input logic [31:0] data);
    applyStimulus(1'b1, BASE + 32'(off), 1'b0, data);
    cycle();
    checkOutput(name);
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();
    checkOutput(name);
  endtask

  task automatic busRead(input string name, input logic [2:0] off, output logic [31:0] data);
    applyStimulus(1'b1, BASE + 32'(off), 1'b1, 32'h0);
    cycle();
    checkOutput(name);
    data = bus.mem_data_out;
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();
    checkOutput(name);
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'hFFFFFF0F, 8'h0F, 32'h0};
    vecs[1] = '{1'b0, 3'd1, 32'h00000030, 8'h3F, 32'h0};
    vecs[2] = '{1'b0, 3'd2, 32'h00000001, 8'h3E, 32'h0};
    vecs[3] = '{1'b0, 3'd3, 32'h000000FF, 8'hC1, 32'h0};
    vecs[4] = '{1'b1, 3'd0, 32'h0,        8'hC1, 32'h000000C1};
    vecs[5] = '{1'b0, 3'd4, 32'h000000FF, 8'hC1, 32'h0};
    vecs[6] = '{1'b1, 3'd4, 32'h0,        8'hC1, 32'h00000000};
    vecs[7] = '{1'b1, 3'd1, 32'h0,        8'hC1, 32'h00000000};
    vecs[8] = '{1'b0, 3'd5, 32'h00000100, 8'hC1, 32'h0};
    vecs[9] = '{1'b1, 3'd5, 32'h0,        8'hC1, 32'h00000000};

    reset = 1'b1; pins = '0; intClr = 1'b0;
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle(); cycle();
    checkOutput("reset");
    checkVal("reset.gpioOut", 32'(gpioOut), 32'h000000A5);
    reset = 1'b0;

    // Scenario 1: read OUT straight after reset
    applyStimulus(1'b1, BASE, 1'b1, 32'h0);
    cycle();
    checkOutput("t1");
    checkVal("t1.ready", 32'(bus.mem_ready), 32'h1);
    checkVal("t1.data", bus.mem_data_out, 32'h000000A5);
    checkVal("t1.irq", 32'(irq), 32'h0);
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();
    checkVal("t1.readyDrop", 32'(bus.mem_ready), 32'h0);

    // Scenario 2: vector table of register accesses
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, BASE + 32'(vecs[i].off), vecs[i].nwr, vecs[i].wdata);
      cycle();
      checkOutput($sformatf("t2.vec%0d", i));
      checkVal($sformatf("t2.vec%0d.out", i), 32'(gpioOut), 32'(vecs[i].expOut));
      if (vecs[i].nwr) checkVal($sformatf("t2.vec%0d.read", i), bus.mem_data_out, vecs[i].expRead);
      applyStimulus(1'b0, BASE, 1'b1, 32'h0);
      cycle();
      checkOutput($sformatf("t2.vec%0d.idle", i));
    end

    applyStimulus(1'b1, BASE + 32'd3, 1'b0, 32'hFF);
    for (int k = 0; k < 5; k++) begin
      cycle();
      checkOutput("t2.heldTgl");
      checkVal("t2.heldTglOnce", 32'(gpioOut), 32'h3E);
    end
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();
    checkVal("t2.heldTglDrop", 32'(bus.mem_ready), 32'h0);

    // Scenario 3: rising-edge latency and disabled falling edge
    busWrite("t3.riseEn", 3'd5, 32'h01);
    busWrite("t3.fallEn", 3'd6, 32'h00);
    pins = 8'h01;
    for (int k = 0; k < S; k++) begin
      cycle();
      checkVal("t3.early", 32'(irq), 32'h0);
    end
    cycle();
    checkVal("t3.latency", 32'(irq), 32'h1);
    busRead("t3.pend", 3'd7, rd);
    checkVal("t3.pendVal", rd, 32'h01);
    busWrite("t3.w1c", 3'd7, 32'h01);
    pins = 8'h00;
    repeat (S + 3) cycle();
    checkVal("t3.noFall", 32'(irq), 32'h0);
    checkOutput("t3.noFall");

    // Scenario 4: W1C on the very cycle a new rising edge lands
    pins = 8'h01;
    repeat (S + 2) cycle();
    checkVal("t4.pendSet", 32'(irq), 32'h1);
    pins = 8'h00;
    repeat (S + 2) cycle();
    pins = 8'h01;
    repeat (S) cycle();
    applyStimulus(1'b1, BASE + 32'd7, 1'b0, 32'h01);
    cycle();
    checkOutput("t4.collide");
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();
    busRead("t4.pend", 3'd7, rd);
    checkVal("t4.setWins", rd, 32'h01);
    busWrite("t4.w1c", 3'd7, 32'h01);
    checkVal("t4.irqOff", 32'(irq), 32'h0);

    // Scenario 5: interrupt_clear, write-only readback, unselected access
    busWrite("t5.riseEn", 3'd5, 32'h80);
    busWrite("t5.fallEn", 3'd6, 32'h01);
    pins = 8'h80;
    repeat (S + 2) cycle();
    busRead("t5.pend", 3'd7, rd);
    checkVal("t5.pendVal", rd, 32'h81);
    intClr = 1'b1;
    cycle();
    intClr = 1'b0;
    checkVal("t5.clrIrq", 32'(irq), 32'h0);
    busRead("t5.pendClr", 3'd7, rd);
    checkVal("t5.pendZero", rd, 32'h00);
    busRead("t5.setRead", 3'd1, rd);
    checkVal("t5.setReadZero", rd, 32'h00);
    applyStimulus(1'b1, BASE - 32'd1, 1'b0, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("t5.unsel");
      checkVal("t5.unselReady", 32'(bus.mem_ready), 32'h0);
      checkVal("t5.unselOut", 32'(gpioOut), 32'h3E);
    end
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    cycle();

    // Scenario 6: reset during a held write, pins high across reset
    applyStimulus(1'b1, BASE, 1'b0, 32'h11);
    pins = 8'hFF;
    cycle();
    checkVal("t6.preReset", 32'(gpioOut), 32'h11);
    reset = 1'b1;
    cycle();
    checkOutput("t6.reset");
    checkVal("t6.resetOut", 32'(gpioOut), 32'h000000A5);
    checkVal("t6.resetReady", 32'(bus.mem_ready), 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, BASE, 1'b1, 32'h0);
    busWrite("t6.riseEn", 3'd5, 32'hFF);
    busWrite("t6.fallEn", 3'd6, 32'hFF);
    repeat (6) cycle();
    checkVal("t6.noSpurious", 32'(irq), 32'h0);
    busRead("t6.pend", 3'd7, rd);
    checkVal("t6.pendZero", rd, 32'h00);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        bus.mem_valid = 1'b0;
      end else if (r == 1) begin
        if ($urandom_range(0, 7) == 0)
          bus.mem_address = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 : BASE + 32'd8;
        else
          bus.mem_address = BASE + 32'($urandom_range(0, 7));
        bus.mem_valid   = 1'b1;
        bus.mem_nwr     = 1'($urandom_range(0, 1));
        bus.mem_data_in = $urandom;
      end
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      intClr = ($urandom_range(0, 15) == 0);
      cycle();
      checkOutput("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
